// File: rtl/panda_data_bus.sv
// Data-side system block: byte-enabled data RAM, memory-mapped UART TX with FIFO,
// and a free-running cycle counter. All accesses complete in the cycle presented.
module panda_data_bus #(
    parameter int unsigned RAM_WORDS    = 1024,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_we_i,
    output logic [31:0] data_rdata_o,
    output logic        uart_tx_o
);

    localparam int unsigned IDX_W  = $clog2(RAM_WORDS);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [29:0]       WORD_TX    = 30'h2000_0000;
    localparam logic [29:0]       WORD_STAT  = 30'h2000_0001;
    localparam logic [29:0]       WORD_CYC   = 30'h2000_0002;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Address decode on the word address; byte offset bits are ignored.
    logic [29:0]      w_word;
    logic [IDX_W-1:0] w_ram_idx;
    logic             w_sel_ram;
    logic             w_sel_tx;
    logic             w_sel_stat;
    logic             w_sel_cyc;
    logic             w_wr_any;
    logic             w_unused;

    assign w_word     = data_addr_i[31:2];
    assign w_ram_idx  = w_word[IDX_W-1:0];
    assign w_sel_ram  = ({2'b00, w_word} < RAM_WORDS);
    assign w_sel_tx   = (w_word == WORD_TX);
    assign w_sel_stat = (w_word == WORD_STAT);
    assign w_sel_cyc  = (w_word == WORD_CYC);
    assign w_wr_any   = |data_we_i;
    assign w_unused   = ^data_addr_i[1:0];

    // Data RAM: contents are deliberately not reset.
    logic [31:0] r_mem [RAM_WORDS];

    always_ff @(posedge clk_i) begin
        if (w_sel_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (data_we_i[i]) begin
                    r_mem[w_ram_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // TX FIFO
    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             w_empty;
    logic             w_full;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;

    logic [1:0]        r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_tx;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FIFO_FULL);
    assign w_push_req = w_sel_tx & data_we_i[0];
    assign w_push     = w_push_req & ~w_full;
    assign w_pop      = (r_state == ST_IDLE) & ~w_empty;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= data_wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // Full is judged before any same-cycle pop, so a push into a full FIFO drops.
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_sel_stat && w_wr_any) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // UART TX state machine
    logic [1:0]        w_state_d;
    logic [BAUD_W-1:0] w_baud_d;
    logic [2:0]        w_bit_d;
    logic [7:0]        w_shift_d;
    logic              w_tx_d;
    logic              w_baud_end;

    assign w_baud_end = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_d = r_state;
        w_baud_d  = r_baud;
        w_bit_d   = r_bit;
        w_shift_d = r_shift;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_d = ST_START;
                    w_baud_d  = '0;
                    w_shift_d = r_fifo[r_rptr];
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    w_state_d = ST_DATA;
                    w_baud_d  = '0;
                    w_bit_d   = '0;
                end else begin
                    w_baud_d = r_baud + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    w_baud_d  = '0;
                    w_shift_d = {1'b0, r_shift[7:1]};
                    w_bit_d   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_d = ST_STOP;
                    end
                end else begin
                    w_baud_d = r_baud + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (w_baud_end) begin
                    w_state_d = ST_IDLE;
                    w_baud_d  = '0;
                end else begin
                    w_baud_d = r_baud + BAUD_W'(1);
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        w_tx_d = 1'b1;
        if (w_state_d == ST_START) begin
            w_tx_d = 1'b0;
        end else if (w_state_d == ST_DATA) begin
            w_tx_d = w_shift_d[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_baud  <= w_baud_d;
            r_bit   <= w_bit_d;
            r_shift <= w_shift_d;
            r_tx    <= w_tx_d;
        end
    end

    assign uart_tx_o = r_tx;

    // Cycle counter: a full-word load counts through its own cycle.
    logic [31:0] r_cycle;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cycle <= '0;
        end else if (w_sel_cyc && (data_we_i == 4'hF)) begin
            r_cycle <= data_wdata_i + 32'd1;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    always_comb begin
        data_rdata_o = '0;
        if (w_sel_ram) begin
            data_rdata_o = r_mem[w_ram_idx];
        end else if (w_sel_stat) begin
            data_rdata_o = {28'b0, r_ovf, (r_state != ST_IDLE), w_full, w_empty};
        end else if (w_sel_cyc) begin
            data_rdata_o = r_cycle;
        end
    end

endmodule

// File: tb/tb_panda_data_bus.sv
// Directed self-checking bench for panda_data_bus: RAM lanes, decode, cycle counter,
// UART framing, FIFO overflow and mid-frame reset.
module tb_panda_data_bus;

    localparam logic [31:0] A_TX  = 32'h8000_0000;
    localparam logic [31:0] A_ST  = 32'h8000_0004;
    localparam logic [31:0] A_CYC = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  we = '0;
    logic [31:0] rdata;
    logic        tx;

    int n_total = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    panda_data_bus #(
        .RAM_WORDS   (1024),
        .FIFO_DEPTH  (4),
        .CLKS_PER_BIT(4)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .data_addr_i (addr),
        .data_wdata_i(wdata),
        .data_we_i   (we),
        .data_rdata_o(rdata),
        .uart_tx_o   (tx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one access for one cycle; checks made after return see it before the edge.
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = w;
        #1;
    endtask

    // Bounded 8N1 receiver sampling mid-bit at 4 clocks per bit.
    task automatic rx_byte(output logic [7:0] b, output bit ok, input int budget);
        ok = 1'b0;
        b  = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            repeat (2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (4) @(negedge clk);
                b[k] = tx;
            end
            repeat (4) @(negedge clk);
            if (tx !== 1'b1) ok = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] pat;
        logic       e;
        int         idx;
        int         lows;

        // Reset state
        #12;
        chk("rst_tx", 32'(tx), 32'd1);
        addr = A_ST;
        #1;
        chk("rst_status", rdata, 32'h1);
        addr = A_CYC;
        #1;
        chk("rst_cycle", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // RAM byte lanes and read-during-write
        drive(32'h0, 32'h1234_5678, 4'hF);
        drive(32'h10, 32'hAABB_CCDD, 4'hF);
        drive(32'h10, 32'h0000_1100, 4'h2);
        drive(32'h10, 32'h0, 4'h0);
        chk("ram_lane", rdata, 32'hAABB_11DD);
        drive(32'h10, 32'hFFFF_FFFF, 4'hF);
        chk("ram_rdw_old", rdata, 32'hAABB_11DD);
        drive(32'h10, 32'h0, 4'h0);
        chk("ram_rdw_new", rdata, 32'hFFFF_FFFF);

        // Out-of-range and unmapped
        drive(32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        chk("oor_wr_rd", rdata, 32'h0);
        drive(32'h8000_000C, 32'hDEAD_BEEF, 4'hF);
        chk("unmap_wr_rd", rdata, 32'h0);
        drive(32'h0000_1000, 32'h0, 4'h0);
        chk("oor_rd", rdata, 32'h0);
        drive(32'h8000_000C, 32'h0, 4'h0);
        chk("unmap_rd", rdata, 32'h0);
        drive(32'h0, 32'h0, 4'h0);
        chk("ram_w0_kept", rdata, 32'h1234_5678);
        drive(A_TX, 32'h0, 4'h0);
        chk("txdata_rd", rdata, 32'h0);

        // Cycle counter load, wrap and partial write
        drive(A_CYC, 32'hFFFF_FFFE, 4'hF);
        drive(A_CYC, 32'h0, 4'h0);
        chk("cyc_0", rdata, 32'hFFFF_FFFF);
        drive(A_CYC, 32'h0, 4'h0);
        chk("cyc_wrap", rdata, 32'h0);
        drive(A_CYC, 32'h0, 4'h0);
        chk("cyc_2", rdata, 32'h1);
        drive(A_CYC, 32'h0, 4'h1);
        chk("cyc_partial", rdata, 32'h2);
        drive(A_CYC, 32'h0, 4'h0);
        chk("cyc_after_partial", rdata, 32'h3);

        // Single UART frame of 0x55
        drive(A_ST, 32'h0, 4'h0);
        chk("st_idle", rdata, 32'h1);
        drive(A_TX, 32'h55, 4'h1);
        drive(A_ST, 32'h0, 4'h0);
        chk("st_queued", rdata, 32'h0);
        chk("tx_pre", 32'(tx), 32'd1);
        pat = 8'h55;
        for (int k = 1; k <= 40; k++) begin
            drive(A_ST, 32'h0, 4'h0);
            idx = (k - 1) / 4;
            if (idx == 0) e = 1'b0;
            else if (idx <= 8) e = pat[idx-1];
            else e = 1'b1;
            chk($sformatf("frame_tx_k%0d", k), 32'(tx), 32'(e));
            chk($sformatf("frame_st_k%0d", k), rdata, 32'h5);
        end
        drive(A_ST, 32'h0, 4'h0);
        chk("st_done", rdata, 32'h1);

        // FIFO full and overflow
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    drive(A_TX, 32'(i), 4'h1);
                end
                drive(A_ST, 32'h0, 4'h0);
                chk("ovf_status", rdata, 32'hE);
            end
            begin
                logic [7:0] b;
                bit         ok;
                for (int f = 0; f < 5; f++) begin
                    rx_byte(b, ok, 100);
                    chk($sformatf("rx_ok_%0d", f), 32'(ok), 32'd1);
                    chk($sformatf("rx_byte_%0d", f), 32'(b), 32'(f + 1));
                end
                rx_byte(b, ok, 60);
                chk("extra_frame", 32'(ok), 32'd0);
            end
        join
        drive(A_ST, 32'h0, 4'h0);
        chk("ovf_sticky", rdata, 32'h9);
        drive(A_ST, 32'h0, 4'h4);
        chk("ovf_clr_cycle", rdata, 32'h9);
        drive(A_ST, 32'h0, 4'h0);
        chk("ovf_cleared", rdata, 32'h1);

        // Reset during DATA bit 3 of 0xA1 with two bytes queued
        drive(A_TX, 32'hA1, 4'h1);
        drive(A_TX, 32'hB2, 4'h1);
        drive(A_TX, 32'hC3, 4'h1);
        addr = A_ST;
        we   = 4'h0;
        repeat (17) @(negedge clk);
        #1;
        chk("pre_rst_bit3", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx", 32'(tx), 32'd1);
        chk("rst_status", rdata, 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("post_rst_no_frame", 32'(lows), 32'd0);
        drive(A_ST, 32'h0, 4'h0);
        chk("post_rst_status", rdata, 32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/panda_data_bus.md
Name: panda_data_bus

Overview:
- Data-side system block directly downstream of the core's MEM-stage data port.
- Consumes the core's data address, write data and byte write enables, and returns load data in the same cycle.
- Decodes the address into three regions:
  - a byte-enabled data RAM;
  - a memory-mapped UART transmitter with a small FIFO;
  - a free-running 32-bit cycle counter.
- Single clock domain. No stalls: every access completes in the cycle it is presented.

Parameters:
- RAM_WORDS, 1024: data RAM depth in 32-bit words; power of two.
- FIFO_DEPTH, 4: UART TX FIFO depth in bytes; power of two, at least 2.
- CLKS_PER_BIT, 434: clock cycles per UART bit; at least 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- data_addr_i  in  32  byte address from the core.
- data_wdata_i  in  32  store data, already lane-aligned by the core LSU.
- data_we_i  in  4  byte write enables; 4'b0000 means read/idle.
- data_rdata_o  out  32  combinational read data for data_addr_i.
- uart_tx_o  out  1  UART serial output, 8N1, idle high.

Behaviour:
- Reset/clock: one clock (clk_i); reset rst_ni is asynchronous and active-low.
- Reset values:
  - uart_tx_o = 1;
  - FIFO empty, read and write pointers 0;
  - TX FSM in IDLE;
  - overflow flag 0;
  - cycle counter 0;
  - data_rdata_o follows the decode, with no registered state.
- RAM contents are not reset.
- Address decode, using addr[31:2] (addr[1:0] ignored):
  - RAM: addr[31] = 0 and word index addr[31:2] < RAM_WORDS.
  - TXDATA: 0x8000_0000.
  - STATUS: 0x8000_0004.
  - CYCLE: 0x8000_0008.
  - Anything else is unmapped: read returns 0, write is ignored.
- RAM:
  - Read is combinational: data_rdata_o = mem[index] in the same cycle (the core registers it into MEM/WB).
  - Write on the clock edge, per byte lane i where data_we_i[i] = 1.
  - A read and write to the same word in the same cycle returns the old contents.
- TXDATA:
  - Read returns 0.
  - A write with data_we_i[0] = 1 pushes data_wdata_i[7:0].
  - If the FIFO is full (evaluated before any same-cycle pop), the byte is dropped and overflow is set to 1 (sticky).
- STATUS read returns {28'b0, overflow, busy, full, empty}:
  - busy = FSM not in IDLE;
  - full and empty describe the FIFO state before the edge.
- STATUS write: any nonzero data_we_i clears overflow. A same-cycle set beats the clear cannot occur, since the write targets different addresses.
- CYCLE:
  - Read returns the counter.
  - Counter increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
  - Write with data_we_i = 4'b1111 loads data_wdata_i; the following cycle reads data_wdata_i + 1.
  - Partial writes are ignored; the counter keeps counting.
- FIFO: circular buffer with pointer wrap at FIFO_DEPTH and a count register 0..FIFO_DEPTH. Simultaneous push and pop when not full leaves the count unchanged.
- TX FSM, each state held for CLKS_PER_BIT cycles by a baud counter:
  - IDLE: uart_tx_o = 1. If the FIFO is not empty, pop the head into a shift register, go to START, baud counter = 0.
  - START: uart_tx_o = 0, then go to DATA with bit index 0.
  - DATA: uart_tx_o = shift[0], LSB first. After each bit, shift right and increment the bit index. After bit 7, go to STOP.
  - STOP: uart_tx_o = 1, then go to IDLE. A pending byte is popped on the next IDLE cycle, so there is 1 idle cycle between frames.
- Frame length is 10*CLKS_PER_BIT cycles.
- Latency from a push into an empty FIFO with the FSM idle to the start-bit falling edge is 1 cycle: pop on the first edge after the push, uart_tx_o low after the second edge.
- Reset mid-frame: uart_tx_o returns to 1 asynchronously and the FIFO contents are discarded.

Test Plan:
- RAM byte lanes:
  - write 0xAABBCCDD to 0x10 with we = 4'b1111;
  - then write 0x00001100 with we = 4'b0010;
  - read 0x10 -> 0xAABB11DD in the same cycle as the address is applied.
- Out-of-range and unmapped accesses (RAM_WORDS = 1024):
  - write to 0x0000_1000 and 0x8000_000C;
  - read both -> 0;
  - RAM word 0 is unchanged.
- UART frame (CLKS_PER_BIT = 4):
  - write 0x55 to TXDATA;
  - uart_tx_o = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles;
  - STATUS busy = 1 during the frame, then reads 0x1.
- FIFO full and overflow (FIFO_DEPTH = 4, CLKS_PER_BIT = 4):
  - 6 back-to-back TXDATA writes 0x01..0x06;
  - the first pops immediately, 4 queue, 0x06 is dropped;
  - STATUS reads 0xE (overflow, busy, full) right after;
  - exactly 5 frames are transmitted;
  - a STATUS write clears overflow.
- Cycle counter:
  - write 0xFFFF_FFFE with we = 4'b1111;
  - consecutive reads -> 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001;
  - a partial write with we = 4'b0001 does not alter counting.
- Reset mid-frame:
  - assert rst_ni low during DATA bit 3 with 2 bytes queued;
  - uart_tx_o = 1 immediately;
  - after release, STATUS = 0x1 and no frame is transmitted.
